// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction buffer accepting 2-slot fetch blocks and issuing one entry per cycle to decode
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [31:0]              fetch_pc,
  input  logic [63:0]              fetch_data,
  input  logic [1:0]               fetch_mask,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   cnt;
  logic [1:0]    n;
  logic          enq, deq;
  assign n           = {1'b0, fetch_mask[0]} + {1'b0, fetch_mask[1]};
  assign fetch_ready = cnt <= (AW+1)'(DEPTH - 2);
  assign dec_valid   = cnt != '0;
  assign enq         = fetch_valid && fetch_ready;
  assign deq         = dec_valid && dec_ready;
  assign dec_pc      = mem[head][63:32];
  assign dec_instr   = mem[head][31:0];
  assign count       = cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq && fetch_mask[0]) mem[tail] <= {fetch_pc, fetch_data[31:0]};
      if (enq && fetch_mask[1]) mem[tail + AW'(fetch_mask[0])] <= {fetch_pc + 32'd4, fetch_data[63:32]};
      if (enq) tail <= tail + AW'(n);
      if (deq) head <= head + AW'(1);
      cnt <= cnt + (enq ? (AW+1)'(n) : '0) - (AW+1)'(deq);
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer against a queue-based reference model
module tb_fetch_buffer;
  localparam int DEPTH = 8;
  logic        clk = 0;
  logic        rst_n, flush, fetch_valid, fetch_ready, dec_valid, dec_ready;
  logic [31:0] fetch_pc, dec_instr, dec_pc;
  logic [63:0] fetch_data;
  logic [1:0]  fetch_mask;
  logic [3:0]  count;
  logic [63:0] q[$];
  int checks = 0, errors = 0;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .fetch_data(fetch_data),
    .fetch_mask(fetch_mask), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush = 0; fetch_valid = 0; dec_ready = 0; fetch_mask = 0; fetch_pc = 0; fetch_data = 0; rst_n = 1;
  endtask

  task automatic tick();
    bit          rst_s = rst_n, fl = flush, fv = fetch_valid, dr = dec_ready;
    bit          room = (DEPTH - q.size()) >= 2, avail = q.size() != 0;
    logic [1:0]  m = fetch_mask;
    logic [31:0] pc = fetch_pc;
    logic [63:0] d = fetch_data;
    @(posedge clk);
    #1;
    if (!rst_s || fl) q.delete();
    else begin
      if (avail && dr) void'(q.pop_front());
      if (fv && room) begin
        if (m[0]) q.push_back({pc, d[31:0]});
        if (m[1]) q.push_back({pc + 32'd4, d[63:32]});
      end
    end
  endtask

  task automatic enq(input logic [31:0] pc, input logic [63:0] d, input logic [1:0] m, input bit dr);
    fetch_valid = 1; fetch_pc = pc; fetch_data = d; fetch_mask = m; dec_ready = dr;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; fetch_valid = 1; fetch_mask = 2'b11; dec_ready = 1;
    tick(); tick();
    idle();
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (dec_valid !== 0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    checks++; if (fetch_ready !== 1) begin errors++; $display("FAIL reset_fetch_ready got %b want 1", fetch_ready); end
    checks++; if (dec_instr !== 0 || dec_pc !== 0) begin errors++; $display("FAIL reset_outputs got %h/%h want 0/0", dec_instr, dec_pc); end
  endtask

  task automatic test_basic();
    enq(32'h1000, 64'h00500093_00100093, 2'b11, 0);
    checks++; if (count !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", count); end
    checks++; if (dec_valid !== 1 || dec_instr !== 32'h00100093 || dec_pc !== 32'h1000) begin errors++; $display("FAIL basic_head got %b %h %h want 1 00100093 00001000", dec_valid, dec_instr, dec_pc); end
    dec_ready = 1; tick();
    checks++; if (dec_valid !== 1 || dec_instr !== 32'h00500093 || dec_pc !== 32'h1004) begin errors++; $display("FAIL basic_second got %b %h %h want 1 00500093 00001004", dec_valid, dec_instr, dec_pc); end
    tick(); idle();
    checks++; if (dec_valid !== 0 || count !== 0) begin errors++; $display("FAIL basic_empty got %b %0d want 0 0", dec_valid, count); end
  endtask

  task automatic test_partial();
    enq(32'h2000, 64'hAAAA0001_BBBB0002, 2'b10, 0);
    checks++; if (count !== 1 || dec_pc !== 32'h2004 || dec_instr !== 32'hAAAA0001) begin errors++; $display("FAIL partial got %0d %h %h want 1 00002004 aaaa0001", count, dec_pc, dec_instr); end
    enq(32'h2100, 64'h1, 2'b00, 0);
    checks++; if (count !== 1 || dec_pc !== 32'h2004) begin errors++; $display("FAIL mask00 got %0d %h want 1 00002004", count, dec_pc); end
    dec_ready = 1; tick(); idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) enq(32'h4000 + 8 * i, {32'(2 * i + 1), 32'(2 * i)}, 2'b11, 0);
    checks++; if (count !== 8 || fetch_ready !== 0 || dec_valid !== 1) begin errors++; $display("FAIL fill_full got %0d %b %b want 8 0 1", count, fetch_ready, dec_valid); end
    fetch_valid = 1; fetch_mask = 2'b11; fetch_pc = 32'h5000; dec_ready = 1; tick();
    checks++; if (count !== 7 || fetch_ready !== 0) begin errors++; $display("FAIL fill_7 got %0d %b want 7 0", count, fetch_ready); end
    fetch_valid = 0; tick(); idle();
    checks++; if (count !== 6 || fetch_ready !== 1 || dec_pc !== 32'h4008) begin errors++; $display("FAIL fill_6 got %0d %b %h want 6 1 00004008", count, fetch_ready, dec_pc); end
    dec_ready = 1; repeat (6) tick(); idle();
  endtask

  task automatic test_wrap();
    idle(); rst_n = 0; tick(); idle();
    for (int i = 0; i < 3; i++) enq(32'h6000 + 8 * i, {32'(100 + 2 * i + 1), 32'(100 + 2 * i)}, 2'b11, 0);
    enq(32'h6018, {32'd0, 32'd106}, 2'b01, 0);
    dec_ready = 1; repeat (4) tick(); idle();
    checks++; if (count !== 3 || dec_pc !== 32'h6010) begin errors++; $display("FAIL wrap_setup got %0d %h want 3 00006010", count, dec_pc); end
    enq(32'h7000, 64'hC0DE0001_C0DE0000, 2'b11, 1);
    checks++; if (count !== 4 || dec_pc !== 32'h6014) begin errors++; $display("FAIL wrap_count got %0d %h want 4 00006014", count, dec_pc); end
    dec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dec_valid !== 1 || {dec_pc, dec_instr} !== q[0]) begin errors++; $display("FAIL wrap_order%0d got %h %h want %h", i, dec_pc, dec_instr, q[0]); end
      tick();
    end
    idle();
    checks++; if (dec_valid !== 0) begin errors++; $display("FAIL wrap_empty got %b want 0", dec_valid); end
  endtask

  task automatic test_flush();
    enq(32'h8000, 64'h1, 2'b11, 0); enq(32'h8008, 64'h2, 2'b11, 0); enq(32'h8010, 64'h3, 2'b01, 0);
    checks++; if (count !== 5) begin errors++; $display("FAIL flush_setup got %0d want 5", count); end
    flush = 1; fetch_valid = 1; fetch_mask = 2'b11; fetch_pc = 32'h9000; dec_ready = 1; tick(); idle();
    checks++; if (count !== 0 || dec_valid !== 0 || fetch_ready !== 1) begin errors++; $display("FAIL flush_prio got %0d %b %b want 0 0 1", count, dec_valid, fetch_ready); end
    enq(32'h3000, 64'h00000013_00000033, 2'b11, 0);
    checks++; if (dec_pc !== 32'h3000 || dec_instr !== 32'h33 || count !== 2) begin errors++; $display("FAIL flush_after got %h %h %0d want 00003000 00000033 2", dec_pc, dec_instr, count); end
  endtask

  task automatic test_reset_mid();
    enq(32'hA000, 64'h5, 2'b11, 0); enq(32'hA008, 64'h6, 2'b11, 0);
    checks++; if (count !== 6) begin errors++; $display("FAIL rstmid_setup got %0d want 6", count); end
    rst_n = 0; fetch_valid = 1; fetch_mask = 2'b11; dec_ready = 1; tick(); idle();
    checks++; if (count !== 0 || dec_valid !== 0 || fetch_ready !== 1 || dec_instr !== 0 || dec_pc !== 0) begin errors++; $display("FAIL rstmid got %0d %b %b %h %h want 0 0 1 0 0", count, dec_valid, fetch_ready, dec_instr, dec_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      flush = ($urandom_range(0, 39) == 0);
      fetch_valid = $urandom_range(0, 2) != 0;
      fetch_mask = 2'($urandom);
      fetch_pc = {$urandom, 3'b000} ;
      fetch_data = {$urandom, $urandom};
      dec_ready = $urandom_range(0, 1);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, q.size()); end
      checks++; if (fetch_ready !== ((DEPTH - q.size()) >= 2) || dec_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_flags cyc %0d got %b %b want %b %b", i, fetch_ready, dec_valid, (DEPTH - q.size()) >= 2, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({dec_pc, dec_instr} !== q[0]) begin errors++; $display("FAIL rnd_head cyc %0d got %h %h want %h", i, dec_pc, dec_instr, q[0]); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_fill();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, number of instruction entries; power of two, minimum 4.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: flush  input  1  discards all buffered entries (redirect or mispredict).
REQ-005 Port: fetch_valid  input  1  fetch presents a 2-instruction block.
REQ-006 Port: fetch_ready  output  1  buffer can accept a full block this cycle.
REQ-007 Port: fetch_pc  input  32  byte address of the lower instruction slot; 8-byte aligned.
REQ-008 Port: fetch_data  input  64  [31:0] instruction at fetch_pc; [63:32] instruction at fetch_pc+4.
REQ-009 Port: fetch_mask  input  2  per-slot valid; bit0 lower slot, bit1 upper slot.
REQ-010 Port: dec_valid  output  1  head entry is presented to decode.
REQ-011 Port: dec_ready  input  1  decode accepts the head entry.
REQ-012 Port: dec_instr  output  32  head instruction word; drives the decode unit's instr field.
REQ-013 Port: dec_pc  output  32  head instruction PC.
REQ-014 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage is a circular buffer of DEPTH entries, each holding {pc[31:0], instr[31:0]}, with head and tail pointers and an occupancy counter.
REQ-016 Enqueue fires when fetch_valid and fetch_ready are both 1.
REQ-017 Dequeue fires when dec_valid and dec_ready are both 1.
REQ-018 fetch_ready is 1 when DEPTH-count >= 2; it is derived only from registered count and has no combinational path from dec_ready or fetch_*.
REQ-019 On enqueue, masked-in slots are written compacted, in order, starting at tail: lower slot first {fetch_pc, fetch_data[31:0]}, then upper slot {fetch_pc+4, fetch_data[63:32]}. Tail advances by popcount(fetch_mask), modulo DEPTH.
REQ-020 An enqueue with fetch_mask=2'b00 changes no state.
REQ-021 dec_valid is 1 when count != 0. dec_instr and dec_pc are read directly from the head entry; there is no enqueue-to-output bypass.
REQ-022 Latency: an entry enqueued at edge N can be presented to decode no earlier than the cycle following edge N.
REQ-023 On dequeue, head advances by 1, modulo DEPTH.
REQ-024 Enqueue and dequeue in the same cycle are both performed; next count = count + popcount(mask) - 1.
REQ-025 Pointers wrap from DEPTH-1 to 0. A 2-slot write starting at DEPTH-1 places the upper slot at entry 0.
REQ-026 When count = DEPTH, dec_valid = 1 and fetch_ready = 0. When count = DEPTH-1, fetch_ready = 0 even if dec_ready = 1.
REQ-027 flush = 1 at an edge sets head = tail = count = 0. It takes priority over a same-cycle enqueue and dequeue; both are discarded and storage contents are not required to change.
REQ-028 When dec_valid = 0, dec_instr and dec_pc show the contents of the entry at head and carry no meaning.
REQ-029 count never exceeds DEPTH and never underflows. A dequeue with count = 0 cannot occur because dec_valid = 0.

Reset
REQ-030 While rst_n = 0 at an edge: head = tail = count = 0, all storage entries = 0, and flush, fetch and dequeue activity are ignored.
REQ-031 Values after reset: dec_valid = 0, dec_instr = 0, dec_pc = 0, count = 0, fetch_ready = 1.
REQ-032 Reset asserted mid-operation discards all entries, with the same result as REQ-030 and REQ-031, regardless of same-cycle handshakes.

Verification
REQ-033 Basic ordering: after reset, enqueue pc=0x1000, data=0x00500093_00100093, mask=2'b11; hold dec_ready=0 -> next cycle count=2, dec_instr=0x00100093, dec_pc=0x1000; assert dec_ready for 2 cycles -> second cycle shows 0x00500093 at 0x1004; then dec_valid=0.
REQ-034 Partial mask: enqueue mask=2'b10, pc=0x2000 -> one entry, dec_pc=0x2004, count=1.
REQ-035 Fill and backpressure (DEPTH=8): 4 full enqueues with dec_ready=0 -> count=8, fetch_ready=0; drain 1 -> count=7, fetch_ready still 0; drain 1 more -> fetch_ready=1.
REQ-036 Wrap with simultaneous operations: set tail=7 and count=3, enqueue mask=2'b11 while dequeuing -> count=4, upper slot stored at entry 0, FIFO order preserved through the wrap.
REQ-037 Flush priority: count=5, flush together with a full enqueue and a dequeue -> next cycle count=0, dec_valid=0, fetch_ready=1; a subsequent enqueue of pc=0x3000 appears first at the head.
REQ-038 Reset mid-operation: count=6 with active handshakes, rst_n=0 for 1 edge -> all REQ-031 values hold.
